lrsc_reservation: RTL and testbench

LRSC_RESERVATION -- requirements
Module: lrsc_reservation

---
 rtl/lrsc_reservation.sv | 118 +++++++++++
 tb/tb_lrsc_reservation.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/lrsc_reservation.sv
// LR/SC reservation tracker: one granule-sized reservation per hart.
// Ports: clk_i/rst_ni (async low); flush_i drops the reservation;
// lr_valid_i/lr_addr_i set it; sc_valid_i/sc_addr_i consume it.
// snoop_valid_i/snoop_addr_i kill a matching reservation.
// sc_result_valid_o/sc_success_o give the SC verdict one cycle later.
// resv_valid_o/resv_addr_o show the held granule base.
// Optional lifetime timeout: define CVA6_LRSC_TIMEOUT_EN.
module lrsc_reservation #(
    parameter int XLEN           = 32,
    parameter int GRANULE_LOG2   = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            lr_valid_i,
    input  logic [XLEN-1:0] lr_addr_i,
    input  logic            sc_valid_i,
    input  logic [XLEN-1:0] sc_addr_i,
    input  logic            snoop_valid_i,
    input  logic [XLEN-1:0] snoop_addr_i,
    output logic            sc_result_valid_o,
    output logic            sc_success_o,
    output logic            resv_valid_o,
    output logic [XLEN-1:0] resv_addr_o
);

    typedef enum logic {
        IDLE     = 1'b0,
        RESERVED = 1'b1
    } state_e;

    localparam logic [XLEN-1:0] GMASK = {XLEN{1'b1}} << GRANULE_LOG2;

    state_e          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            rvalid_q, rvalid_d;
    logic            succ_q, succ_d;

    logic            resv;
    logic            sc_hit;
    logic            snoop_hit;
    logic            expired;

    assign resv      = (state_q == RESERVED);
    assign sc_hit    = ((sc_addr_i ^ addr_q) & GMASK) == '0;
    assign snoop_hit = snoop_valid_i && resv &&
                       (((snoop_addr_i ^ addr_q) & GMASK) == '0);

`ifdef CVA6_LRSC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Counter sits at zero for one RESERVED cycle before the drop;
    // an SC landing in that cycle is refused.
    assign expired = resv && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (lr_valid_i && !flush_i) begin
            cnt_d = CW'(TIMEOUT_CYCLES);
        end else if (resv && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout;

    assign expired        = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    // Priority: flush, then SC/snoop against the old reservation, then LR.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rvalid_d = sc_valid_i;
        succ_d   = sc_valid_i && resv && sc_hit && !flush_i &&
                   !snoop_hit && !expired;
        if (flush_i) begin
            state_d = IDLE;
        end else if (lr_valid_i) begin
            state_d = RESERVED;
            addr_d  = lr_addr_i & GMASK;
        end else if (sc_valid_i || snoop_hit || expired) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            rvalid_q <= 1'b0;
            succ_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rvalid_q <= rvalid_d;
            succ_q   <= succ_d;
        end
    end

    assign sc_result_valid_o = rvalid_q;
    assign sc_success_o      = succ_q;
    assign resv_valid_o      = resv;
    assign resv_addr_o       = addr_q;

endmodule

// File: tb/tb_lrsc_reservation.sv
// Directed vector bench for lrsc_reservation.
// Table of single-cycle vectors plus reset and lifetime sequences.
module tb_lrsc_reservation;

    logic        clk;
    logic        rst_ni;
    logic        flush_i;
    logic        lr_valid_i;
    logic [31:0] lr_addr_i;
    logic        sc_valid_i;
    logic [31:0] sc_addr_i;
    logic        snoop_valid_i;
    logic [31:0] snoop_addr_i;
    logic        sc_result_valid_o;
    logic        sc_success_o;
    logic        resv_valid_o;
    logic [31:0] resv_addr_o;

    int checks   = 0;
    int failures = 0;

    lrsc_reservation #(
        .XLEN          (32),
        .GRANULE_LOG2  (3),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .flush_i          (flush_i),
        .lr_valid_i       (lr_valid_i),
        .lr_addr_i        (lr_addr_i),
        .sc_valid_i       (sc_valid_i),
        .sc_addr_i        (sc_addr_i),
        .snoop_valid_i    (snoop_valid_i),
        .snoop_addr_i     (snoop_addr_i),
        .sc_result_valid_o(sc_result_valid_o),
        .sc_success_o     (sc_success_o),
        .resv_valid_o     (resv_valid_o),
        .resv_addr_o      (resv_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        lr;
        logic [31:0] lra;
        logic        sc;
        logic [31:0] sca;
        logic        sn;
        logic [31:0] sna;
        logic        e_rv;
        logic        e_s;
        logic        e_v;
        logic [31:0] e_a;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(
        input logic fl, input logic lr, input logic [31:0] lra,
        input logic sc, input logic [31:0] sca,
        input logic sn, input logic [31:0] sna,
        input logic e_rv, input logic e_s, input logic e_v,
        input logic [31:0] e_a);
        vec_t v;
        v.fl = fl; v.lr = lr; v.lra = lra;
        v.sc = sc; v.sca = sca;
        v.sn = sn; v.sna = sna;
        v.e_rv = e_rv; v.e_s = e_s; v.e_v = e_v; v.e_a = e_a;
        return v;
    endfunction

    // Address only compared while a reservation is expected.
    task automatic chk(input string nm, input logic rv, input logic s,
                       input logic v, input logic [31:0] a);
        logic bad;
        checks++;
        bad = (sc_result_valid_o !== rv) || (sc_success_o !== s) ||
              (resv_valid_o !== v) || (v && (resv_addr_o !== a));
        if (bad) begin
            failures++;
            $display("FAIL %s: got rv=%b s=%b v=%b a=%h want rv=%b s=%b v=%b a=%h",
                     nm, sc_result_valid_o, sc_success_o, resv_valid_o,
                     resv_addr_o, rv, s, v, a);
        end
    endtask

    task automatic step(input logic fl, input logic lr, input logic [31:0] lra,
                        input logic sc, input logic [31:0] sca,
                        input logic sn, input logic [31:0] sna);
        flush_i       = fl;
        lr_valid_i    = lr;
        lr_addr_i     = lra;
        sc_valid_i    = sc;
        sc_addr_i     = sca;
        snoop_valid_i = sn;
        snoop_addr_i  = sna;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_ni = 1'b0;
        flush_i = 0; lr_valid_i = 0; lr_addr_i = 0;
        sc_valid_i = 0; sc_addr_i = 0;
        snoop_valid_i = 0; snoop_addr_i = 0;
        #3;
        chk("reset", 0, 0, 0, 0);
        if (resv_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_addr: got %h want 0", resv_addr_o);
        end
        checks++;
        @(negedge clk);
        rst_ni = 1'b1;

        //           fl lr lra           sc sca           sn sna           rv s  v  addr
        vt.push_back(mk(0, 0, 0,            0, 0,            0, 0,            0, 0, 0, 0));
        vt.push_back(mk(0, 1, 32'h80001004, 0, 0,            0, 0,            0, 0, 1, 32'h80001000));
        vt.push_back(mk(0, 0, 0,            0, 0,            0, 0,            0, 0, 1, 32'h80001000));
        vt.push_back(mk(0, 0, 0,            0, 0,            0, 0,            0, 0, 1, 32'h80001000));
        vt.push_back(mk(0, 0, 0,            1, 32'h80001000, 0, 0,            1, 1, 0, 0));
        vt.push_back(mk(0, 0, 0,            0, 0,            0, 0,            0, 0, 0, 0));
        vt.push_back(mk(0, 1, 32'h80001000, 0, 0,            0, 0,            0, 0, 1, 32'h80001000));
        vt.push_back(mk(0, 0, 0,            0, 0,            1, 32'h80001006, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0,            1, 32'h80001000, 0, 0,            1, 0, 0, 0));
        vt.push_back(mk(0, 1, 32'h80001000, 0, 0,            0, 0,            0, 0, 1, 32'h80001000));
        vt.push_back(mk(0, 0, 0,            0, 0,            1, 32'h80001008, 0, 0, 1, 32'h80001000));
        vt.push_back(mk(0, 0, 0,            1, 32'h80001000, 0, 0,            1, 1, 0, 0));
        vt.push_back(mk(0, 1, 32'h100,      1, 32'h100,      0, 0,            1, 0, 1, 32'h100));
        vt.push_back(mk(0, 0, 0,            0, 0,            0, 0,            0, 0, 1, 32'h100));
        vt.push_back(mk(1, 0, 0,            0, 0,            0, 0,            0, 0, 0, 0));
        vt.push_back(mk(1, 1, 32'h200,      0, 0,            0, 0,            0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0,            1, 32'h200,      0, 0,            1, 0, 0, 0));
        vt.push_back(mk(0, 1, 32'h400,      0, 0,            0, 0,            0, 0, 1, 32'h400));
        vt.push_back(mk(0, 0, 0,            1, 32'h408,      0, 0,            1, 0, 0, 0));
        vt.push_back(mk(0, 1, 32'h500,      0, 0,            0, 0,            0, 0, 1, 32'h500));
        vt.push_back(mk(0, 1, 32'h606,      0, 0,            0, 0,            0, 0, 1, 32'h600));
        vt.push_back(mk(0, 0, 0,            1, 32'h500,      0, 0,            1, 0, 0, 0));
        vt.push_back(mk(0, 1, 32'h700,      0, 0,            0, 0,            0, 0, 1, 32'h700));
        vt.push_back(mk(0, 1, 32'h800,      1, 32'h707,      0, 0,            1, 1, 1, 32'h800));
        vt.push_back(mk(0, 0, 0,            1, 32'h800,      0, 0,            1, 1, 0, 0));
        vt.push_back(mk(0, 1, 32'h900,      0, 0,            0, 0,            0, 0, 1, 32'h900));
        vt.push_back(mk(0, 1, 32'hA00,      0, 0,            1, 32'h900,      0, 0, 1, 32'hA00));
        vt.push_back(mk(0, 0, 0,            1, 32'hA00,      1, 32'hA04,      1, 0, 0, 0));
        vt.push_back(mk(0, 1, 32'hB00,      0, 0,            0, 0,            0, 0, 1, 32'hB00));
        vt.push_back(mk(1, 0, 0,            1, 32'hB00,      0, 0,            1, 0, 0, 0));
        vt.push_back(mk(0, 0, 0,            0, 0,            1, 32'hB00,      0, 0, 0, 0));

        foreach (vt[i]) begin
            step(vt[i].fl, vt[i].lr, vt[i].lra, vt[i].sc, vt[i].sca,
                 vt[i].sn, vt[i].sna);
            chk($sformatf("vec%0d", i), vt[i].e_rv, vt[i].e_s, vt[i].e_v,
                vt[i].e_a);
        end

        // Reset asserted while an SC is being presented.
        step(0, 1, 32'hC00, 0, 0, 0, 0);
        chk("rst_a_lr", 0, 0, 1, 32'hC00);
        sc_valid_i = 1; sc_addr_i = 32'hC00; lr_valid_i = 0;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rst_a_async", 0, 0, 0, 0);
        sc_valid_i = 0;
        @(posedge clk);
        #1;
        chk("rst_a_held", 0, 0, 0, 0);
        @(negedge clk);
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle();
            chk($sformatf("rst_a_post%0d", i), 0, 0, 0, 0);
        end

        // Reset in the cycle after the SC: pending strobe must vanish.
        step(0, 1, 32'hD00, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'hD00, 0, 0);
        chk("rst_b_sc", 1, 1, 0, 0);
        rst_ni = 1'b0;
        #1;
        chk("rst_b_async", 0, 0, 0, 0);
        @(negedge clk);
        rst_ni = 1'b1;
        for (int i = 0; i < 2; i++) begin
            idle();
            chk($sformatf("rst_b_post%0d", i), 0, 0, 0, 0);
        end

`ifdef CVA6_LRSC_TIMEOUT_EN
        // SC within the lifetime succeeds.
        step(0, 1, 32'h300, 0, 0, 0, 0);
        idle();
        idle();
        step(0, 0, 0, 1, 32'h300, 0, 0);
        chk("to_sc3", 1, 1, 0, 0);
        idle();
        // Reservation drops 5 cycles after the LR; late SC fails.
        step(0, 1, 32'h300, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            idle();
            chk($sformatf("to_hold%0d", i), 0, 0, 1, 32'h300);
        end
        idle();
        chk("to_drop", 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h300, 0, 0);
        chk("to_sc6", 1, 0, 0, 0);
        idle();
        // SC in the counter-at-zero cycle is refused.
        step(0, 1, 32'h300, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) idle();
        step(0, 0, 0, 1, 32'h300, 0, 0);
        chk("to_sc5", 1, 0, 0, 0);
        idle();
`else
        // Without the timeout the reservation persists indefinitely.
        step(0, 1, 32'h300, 0, 0, 0, 0);
        for (int i = 0; i < 80; i++) idle();
        chk("no_to_hold", 0, 0, 1, 32'h300);
        step(0, 0, 0, 1, 32'h300, 0, 0);
        chk("no_to_sc", 1, 1, 0, 0);
        idle();
`endif
        chk("final_idle", 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
